// File: rtl/call_ret_seq_if.sv
// Bundle between the call/return sequencer and its surroundings.
// The master side is the upstream op source plus the return-address stack;
// the slave side is the sequencer itself.
interface call_ret_seq_if #(
  parameter int PC_W = 12,
  parameter int SP_W = 2
);
  logic            stall;
  logic            op_step;
  logic            op_jmp;
  logic            op_call;
  logic            op_ret;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] stk0;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pcx;
  logic            push;
  logic            pop;
  logic [SP_W-1:0] sp;
  logic            busy;
  logic            ovf;
  logic            unf;

  modport master (
    output stall, op_step, op_jmp, op_call, op_ret, target, stk0,
    input  pc, pcx, push, pop, sp, busy, ovf, unf
  );

  modport slave (
    input  stall, op_step, op_jmp, op_call, op_ret, target, stk0,
    output pc, pcx, push, pop, sp, busy, ovf, unf
  );
endinterface

// File: rtl/call_ret_seq.sv
// Program-counter sequencer in front of a return-address stack.
// Owns pc and the stack index; a call pushes pc+1 and jumps, a return pops,
// waits for the registered stack read and reloads pc from it (3 cycles).
// Optional macro CALL_RET_SP_CHECK_EN: a call with the stack full or a return
// with it empty raises sticky ovf/unf and parks the block in FAULT until rst.
// Without it the index wraps, overwriting the oldest entry or reading stale data.
module call_ret_seq #(
  parameter int              PC_W   = 12,
  parameter int              DEPTH  = 4,
  parameter int              SP_W   = 2,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input logic           clk,
  input logic           rst,
  call_ret_seq_if.slave bus
);

  typedef enum logic [1:0] {RUN, RET_RD, RET_LD, FAULT} state_t;

  localparam logic [SP_W:0] DEPTH_C = (SP_W + 1)'(DEPTH);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [SP_W-1:0] sp_q, sp_nxt;
  logic [SP_W:0]   count_q, count_nxt;
  logic            ovf_q, ovf_nxt;
  logic            unf_q, unf_nxt;
  logic            full, empty;
  logic            call_fault, ret_fault;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

`ifdef CALL_RET_SP_CHECK_EN
  // Stack bounds are enforced: an illegal call/return traps instead of wrapping.
  assign call_fault = full;
  assign ret_fault  = empty;
`else
  // Stack index wraps freely; FAULT is never entered.
  assign call_fault = 1'b0;
  assign ret_fault  = 1'b0;
`endif

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc_q    <= RST_PC;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      sp_q    <= sp_nxt;
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  // Next-state decode: op priority call > ret > jmp > step while running.
  // NOTE: every target gets a hold default first so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    sp_nxt    = sp_q;
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    case (state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.op_call) begin
            if (call_fault) begin
              ovf_nxt   = 1'b1;
              state_nxt = FAULT;
            end else begin
              pc_nxt = bus.target;
              sp_nxt = sp_q + 1'b1;
              if (!full) count_nxt = count_q + 1'b1;
            end
          end else if (bus.op_ret) begin
            if (ret_fault) begin
              unf_nxt   = 1'b1;
              state_nxt = FAULT;
            end else begin
              sp_nxt    = sp_q - 1'b1;
              if (!empty) count_nxt = count_q - 1'b1;
              state_nxt = RET_RD;
            end
          end else if (bus.op_jmp) begin
            pc_nxt = bus.target;
          end else if (bus.op_step) begin
            pc_nxt = pc_q + 1'b1;
          end
        end
      end
      // sp now addresses the popped slot; the stack registers it this cycle.
      RET_RD:  state_nxt = RET_LD;
      RET_LD: begin
        pc_nxt    = bus.stk0;
        state_nxt = RUN;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: push/pop/pcx are combinational, the rest come from registers.
  always_comb begin
    bus.push = (state == RUN) && !bus.stall && bus.op_call && !call_fault;
    bus.pop  = (state == RUN) && !bus.stall && !bus.op_call && bus.op_ret && !ret_fault;
    bus.pcx  = pc_q + 1'b1;
    bus.busy = (state != RUN);
    bus.pc   = pc_q;
    bus.sp   = sp_q;
    bus.ovf  = ovf_q;
    bus.unf  = unf_q;
  end

endmodule

// File: tb/tb_call_ret_seq.sv
// Self-checking bench for call_ret_seq: directed scenarios plus a randomized
// run against a behavioural model (return-address array + return latency).
module tb_call_ret_seq;
  localparam int PC_W  = 12;
  localparam int DEPTH = 4;
  localparam int SP_W  = 2;
`ifdef CALL_RET_SP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  call_ret_seq_if #(.PC_W(PC_W), .SP_W(SP_W)) bus();

  call_ret_seq #(.PC_W(PC_W), .DEPTH(DEPTH), .SP_W(SP_W), .RST_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Return-address stack: synchronous write, registered read of slot sp.
  logic [PC_W-1:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (bus.push) ram[bus.sp] <= bus.pcx;
    bus.stk0 <= ram[bus.sp];
  end

  // Behavioural model.
  int m_pc, m_sp, m_count, m_wait, m_ret;
  bit m_fault, m_ovf, m_unf;
  int m_stack [DEPTH] = '{default: 0};

  task automatic apply(input bit c, input bit r, input bit j, input bit s,
                       input bit st, input logic [PC_W-1:0] t);
    bus.op_call = c; bus.op_ret = r; bus.op_jmp = j; bus.op_step = s;
    bus.stall = st;  bus.target = t;
  endtask

  task automatic model_reset();
    m_pc = 0; m_sp = 0; m_count = 0; m_wait = 0; m_ret = 0;
    m_fault = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge();
    if (m_fault) begin
      // frozen until reset
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_pc = m_ret;
    end else if (!bus.stall) begin
      if (bus.op_call) begin
        if (CHK && m_count == DEPTH) begin
          m_ovf = 1; m_fault = 1;
        end else begin
          m_stack[m_sp] = (m_pc + 1) % 4096;
          m_sp = (m_sp + 1) % DEPTH;
          if (m_count < DEPTH) m_count++;
          m_pc = int'(bus.target);
        end
      end else if (bus.op_ret) begin
        if (CHK && m_count == 0) begin
          m_unf = 1; m_fault = 1;
        end else begin
          m_sp = (m_sp + DEPTH - 1) % DEPTH;
          if (m_count > 0) m_count--;
          m_ret  = m_stack[m_sp];
          m_wait = 2;
        end
      end else if (bus.op_jmp) begin
        m_pc = int'(bus.target);
      end else if (bus.op_step) begin
        m_pc = (m_pc + 1) % 4096;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", bus.pc); end
    n_tests++; if (bus.sp !== 2'd0) begin n_fail++; $display("FAIL reset_sp got %0d exp 0", bus.sp); end
    n_tests++; if ({bus.busy, bus.push, bus.pop, bus.ovf, bus.unf} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {bus.busy, bus.push, bus.pop, bus.ovf, bus.unf}); end
  endtask

  task automatic test_step_jmp();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 0, 1, 0, '0); tick();
      n_tests++; if (bus.pc !== 12'(i)) begin n_fail++; $display("FAIL step%0d pc got %h exp %h", i, bus.pc, 12'(i)); end
    end
    apply(0, 0, 1, 0, 0, 12'h1A0); tick();
    n_tests++; if (bus.pc !== 12'h1A0) begin n_fail++; $display("FAIL jmp pc got %h exp 1a0", bus.pc); end
    apply(0, 0, 1, 0, 0, 12'hFFF); tick();
    apply(0, 0, 0, 1, 0, '0); tick();
    n_tests++; if (bus.pc !== 12'h000) begin n_fail++; $display("FAIL pc_wrap got %h exp 000", bus.pc); end
  endtask

  task automatic test_call_ret();
    do_reset();
    apply(0, 0, 1, 0, 0, 12'h010); tick();
    apply(1, 0, 0, 0, 0, 12'h200); #1;
    n_tests++; if (bus.push !== 1'b1 || bus.pcx !== 12'h011) begin n_fail++; $display("FAIL call_push got push=%b pcx=%h exp 1/011", bus.push, bus.pcx); end
    tick();
    n_tests++; if (bus.sp !== 2'd1 || bus.pc !== 12'h200) begin n_fail++; $display("FAIL call_state got sp=%0d pc=%h exp 1/200", bus.sp, bus.pc); end
    apply(0, 1, 0, 0, 0, '0); #1;
    n_tests++; if (bus.pop !== 1'b1) begin n_fail++; $display("FAIL ret_pop got %b exp 1", bus.pop); end
    tick(); apply(0, 0, 0, 0, 0, '0);
    n_tests++; if (bus.busy !== 1'b1 || bus.sp !== 2'd0 || bus.pop !== 1'b0) begin n_fail++; $display("FAIL ret_rd got busy=%b sp=%0d pop=%b exp 1/0/0", bus.busy, bus.sp, bus.pop); end
    tick();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ret_ld busy got %b exp 1", bus.busy); end
    tick();
    n_tests++; if (bus.pc !== 12'h011 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ret_done got pc=%h busy=%b exp 011/0", bus.pc, bus.busy); end
  endtask

  task automatic test_nested();
    do_reset();
    apply(0, 0, 1, 0, 0, 12'h100); tick();
    for (int i = 1; i <= 4; i++) begin
      apply(1, 0, 0, 0, 0, 12'((i + 1) * 256)); tick();
    end
    for (int i = 4; i >= 1; i--) begin
      apply(0, 1, 0, 0, 0, '0); tick();
      apply(0, 0, 0, 0, 0, '0); tick(); tick();
      n_tests++; if (bus.pc !== 12'(i * 256 + 1)) begin n_fail++; $display("FAIL nested_ret%0d pc got %h exp %h", i, bus.pc, 12'(i * 256 + 1)); end
    end
    n_tests++; if (bus.sp !== 2'd0) begin n_fail++; $display("FAIL nested_sp got %0d exp 0", bus.sp); end
  endtask

  task automatic test_overflow();
    do_reset();
    apply(0, 0, 1, 0, 0, 12'h100); tick();
    for (int i = 1; i <= 4; i++) begin
      apply(1, 0, 0, 0, 0, 12'((i + 1) * 256)); tick();
    end
    apply(1, 0, 0, 0, 0, 12'h700); #1;
    if (CHK) begin
      n_tests++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL ovf_push got %b exp 0", bus.push); end
      tick();
      n_tests++; if (bus.ovf !== 1'b1 || bus.busy !== 1'b1 || bus.pc !== 12'h500 || bus.sp !== 2'd0) begin n_fail++; $display("FAIL ovf_state got ovf=%b busy=%b pc=%h sp=%0d exp 1/1/500/0", bus.ovf, bus.busy, bus.pc, bus.sp); end
    end else begin
      n_tests++; if (bus.push !== 1'b1 || bus.pcx !== 12'h501) begin n_fail++; $display("FAIL wrap_push got push=%b pcx=%h exp 1/501", bus.push, bus.pcx); end
      tick();
      n_tests++; if (bus.ovf !== 1'b0 || bus.sp !== 2'd1 || ram[0] !== 12'h501) begin n_fail++; $display("FAIL wrap_state got ovf=%b sp=%0d slot0=%h exp 0/1/501", bus.ovf, bus.sp, ram[0]); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(0, 1, 0, 0, 0, '0); #1;
    if (CHK) begin
      n_tests++; if (bus.pop !== 1'b0) begin n_fail++; $display("FAIL unf_pop got %b exp 0", bus.pop); end
      tick();
      n_tests++; if (bus.unf !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL unf_state got unf=%b busy=%b exp 1/1", bus.unf, bus.busy); end
    end else begin
      n_tests++; if (bus.pop !== 1'b1) begin n_fail++; $display("FAIL unf_wrap_pop got %b exp 1", bus.pop); end
      tick();
      n_tests++; if (bus.unf !== 1'b0 || bus.sp !== 2'd3) begin n_fail++; $display("FAIL unf_wrap got unf=%b sp=%0d exp 0/3", bus.unf, bus.sp); end
      apply(0, 0, 0, 0, 0, '0); tick(); tick();
    end
  endtask

  task automatic test_priority_stall();
    do_reset();
    apply(0, 0, 1, 0, 0, 12'h050); tick();
    apply(1, 1, 0, 0, 0, 12'h300); #1;
    n_tests++; if (bus.push !== 1'b1 || bus.pop !== 1'b0) begin n_fail++; $display("FAIL prio_comb got push=%b pop=%b exp 1/0", bus.push, bus.pop); end
    tick();
    n_tests++; if (bus.pc !== 12'h300 || bus.sp !== 2'd1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL prio_state got pc=%h sp=%0d busy=%b exp 300/1/0", bus.pc, bus.sp, bus.busy); end
    apply(1, 0, 0, 0, 1, 12'h555); #1;
    n_tests++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL stall_push got %b exp 0", bus.push); end
    tick();
    n_tests++; if (bus.pc !== 12'h300 || bus.sp !== 2'd1) begin n_fail++; $display("FAIL stall_hold got pc=%h sp=%0d exp 300/1", bus.pc, bus.sp); end
    apply(0, 1, 0, 0, 0, '0); tick();
    apply(0, 0, 0, 0, 1, '0); tick(); tick();
    n_tests++; if (bus.pc !== 12'h051 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_ret got pc=%h busy=%b exp 051/0", bus.pc, bus.busy); end
    apply(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset_mid_return();
    do_reset();
    apply(0, 0, 1, 0, 0, 12'h020); tick();
    apply(1, 0, 0, 0, 0, 12'h600); tick();
    apply(0, 1, 0, 0, 0, '0); tick();
    apply(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_tests++; if (bus.pc !== 12'h000 || bus.sp !== 2'd0 || bus.busy !== 1'b0 || bus.pop !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ret got pc=%h sp=%0d busy=%b pop=%b exp 000/0/0/0", bus.pc, bus.sp, bus.busy, bus.pop); end
    rst = 1'b0; #1;
  endtask

  task automatic test_random();
    logic            e_push, e_pop;
    logic [PC_W-1:0] e_pcx;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_fault && $urandom_range(0, 3) == 0) do_reset();
      apply($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, PC_W'($urandom));
      #1;
      e_push = !m_fault && m_wait == 0 && !bus.stall && bus.op_call && !(CHK && m_count == DEPTH);
      e_pop  = !m_fault && m_wait == 0 && !bus.stall && !bus.op_call && bus.op_ret && !(CHK && m_count == 0);
      e_pcx  = PC_W'(m_pc + 1);
      n_tests++; if (bus.push !== e_push || bus.pop !== e_pop || bus.pcx !== e_pcx) begin n_fail++; $display("FAIL rnd%0d_comb got push=%b pop=%b pcx=%h exp %b/%b/%h", n, bus.push, bus.pop, bus.pcx, e_push, e_pop, e_pcx); end
      tick();
      n_tests++; if (bus.pc !== PC_W'(m_pc) || bus.sp !== SP_W'(m_sp) || bus.busy !== (m_fault || m_wait > 0) || bus.ovf !== m_ovf || bus.unf !== m_unf) begin n_fail++; $display("FAIL rnd%0d_state got pc=%h sp=%0d busy=%b ovf=%b unf=%b exp %h/%0d/%b/%b/%b", n, bus.pc, bus.sp, bus.busy, bus.ovf, bus.unf, PC_W'(m_pc), m_sp, (m_fault || m_wait > 0), m_ovf, m_unf); end
    end
  endtask

  initial begin
    apply(0, 0, 0, 0, 0, '0);
    test_reset();
    test_step_jmp();
    test_call_ret();
    test_nested();
    test_overflow();
    test_underflow();
    test_priority_stall();
    test_reset_mid_return();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/call_ret_seq.md
Name: call_ret_seq

Overview:
- Program-counter sequencer that sits directly upstream of the return-address stack.
- Owns the PC and the stack index, and decides on each cycle whether the PC steps, jumps, calls or returns.
- Drives the stack's write data (pcx), write enable (push) and address (sp), and consumes the stack's registered read data (stk0) to complete a return.
- Replaces a free-running stack index so that push/pop and the PC stay consistent, with optional overflow/underflow protection.

Parameters:
- PC_W, 12, PC and return-address width
- DEPTH, 4, stack entries; must be a power of two
- SP_W, 2, stack index width, equal to log2(DEPTH)
- RST_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze: no PC or sp change, no push, no pop
- op_step  in  1  advance PC by 1
- op_jmp  in  1  load PC from target
- op_call  in  1  push PC+1 to the stack, then load PC from target
- op_ret  in  1  pop the stack, then load PC from the popped entry
- target  in  PC_W  jump/call destination
- stk0  in  PC_W  registered stack read data; valid 1 cycle after sp is stable
- pc  out  PC_W  current program counter
- pcx  out  PC_W  return address written to the stack, equal to pc+1 (mod 2^PC_W)
- push  out  1  stack write enable, writes the entry at sp
- pop  out  1  one-cycle pulse on each accepted return
- sp  out  SP_W  stack index: next free slot while in RUN
- busy  out  1  high while a return is in progress or in FAULT; op_* ignored
- ovf  out  1  sticky: call attempted with the stack full
- unf  out  1  sticky: return attempted with the stack empty

Behaviour:
- Reset, asynchronous: pc=RST_PC, sp=0, count=0, push=0, pop=0, busy=0, ovf=0, unf=0, state=RUN.
- push, pop and pcx are combinational from state and inputs; everything else is registered.
- count is internal, SP_W+1 bits wide, range 0..DEPTH.
- States: RUN, RET_RD, RET_LD, FAULT.
- RUN with stall=1: hold everything.
- RUN with stall=0, priority call > ret > jmp > step:
  - call: push=1 for this cycle with pcx=pc+1; pc<=target; sp<=sp+1 (mod DEPTH); count+1.
  - ret: pop=1; sp<=sp-1 (mod DEPTH); count-1; go to RET_RD; busy=1 from the next cycle.
  - jmp: pc<=target.
  - step: pc<=pc+1, wrapping from 0xFFF to 0x000.
  - none: hold.
- RET_RD: sp is stable at the popped slot and the stack registers stk0 at the end of this cycle. No other action; go to RET_LD.
- RET_LD: pc<=stk0; go to RUN. A return therefore takes 3 cycles; the next op is accepted on the cycle after RET_LD.
- stall is ignored in RET_RD and RET_LD: a return, once started, always completes.
- op_* inputs are ignored in RET_RD, RET_LD and FAULT. Upstream must hold ops while busy=1.
- Simultaneous call and ret: call wins; ret is dropped, with no error.
- Back-to-back calls: one push per cycle; sp increments each cycle.
- A call issued in the cycle after RET_LD pushes the slot just freed.

Optional Feature:
- Macro: CALL_RET_SP_CHECK_EN.
- Defined:
  - A call with count==DEPTH sets ovf; no push, pc and sp unchanged; state goes to FAULT.
  - A ret with count==0 sets unf; no pop; state goes to FAULT.
  - FAULT holds pc and sp, busy=1; only rst exits it.
- Undefined:
  - ovf and unf are tied to 0.
  - sp wraps modulo DEPTH: the oldest entry is overwritten on overflow, and an underflow returns stale data.
  - FAULT is unreachable.

Test Plan:
- Reset mid-return: assert rst in RET_RD -> next cycle pc=RST_PC, sp=0, busy=0, pop=0.
- Step/jump: from pc=0x000, step x3 then jmp target=0x1A0 -> pc=0x001, 0x002, 0x003, 0x1A0; PC wrap 0xFFF->0x000 on step.
- Call/return: pc=0x010, call target=0x200 -> push=1, pcx=0x011, sp 0->1. Then ret -> pop=1, busy high for 2 cycles, pc=0x011 on the third cycle, sp=0.
- Nested depth: 4 calls from pc=0x100/0x200/0x300/0x400 then 4 rets -> pc sequence 0x401, 0x301, 0x201, 0x101.
- Overflow/underflow (CALL_RET_SP_CHECK_EN):
  - 5th call -> ovf=1, push=0, busy=1, pc frozen.
  - ret after reset -> unf=1, pop=0.
- Overflow without the macro: 5th call overwrites slot 0, ovf stays 0.
- Priority and stall: call+ret together -> call only. stall=1 with op_call -> push=0, pc unchanged. stall raised during RET_RD -> return still completes on schedule.
